// File: rtl/btn_debounce_pulse_if.sv
// Pushbutton front-end signal bundle: raw button and repeat enable in,
// debounced level, enable pulse, repeat flag and FSM state out.
interface btn_debounce_pulse_if;
  logic       btn_in;         // raw pushbutton, asynchronous, active-high
  logic       rpt_en;         // auto-repeat enable, synchronous to clk
  logic       ena_pulse;      // one-cycle enable pulse per press/repeat
  logic       btn_level;      // debounced button level
  logic       repeat_active;  // high while auto-repeating
  logic [2:0] dbg_state;      // current FSM state, for observation only

  // master: whoever owns the button and consumes the pulses
  modport master (
    output btn_in,
    output rpt_en,
    input  ena_pulse,
    input  btn_level,
    input  repeat_active,
    input  dbg_state
  );

  // slave: the debouncer itself
  modport slave (
    input  btn_in,
    input  rpt_en,
    output ena_pulse,
    output btn_level,
    output repeat_active,
    output dbg_state
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Pushbutton debouncer with single-cycle enable pulses and optional
// auto-repeat. The raw button passes a two-flop synchronizer; a five-state
// FSM with one shared timer debounces press and release and times repeats.
// There is no handshake here: btn_in/rpt_en are sampled every cycle and
// ena_pulse is a plain one-cycle strobe with no back-pressure.
module btn_debounce_pulse #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int TIMER_W       = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_debounce_pulse_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Terminal timer values; a state acts when the timer reaches these.
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO  = '0;

  logic               sync1_q;
  logic               sync_q;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ena_q, ena_d;
  logic               level_q, level_d;
  logic               rpt_act_q, rpt_act_d;

  // Two-flop synchronizer for the asynchronous button; only sync_q is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync_q  <= sync1_q;
    end
  end

  // Next-state, timer and output decode; every transition sets the timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ena_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = DEB_PRESS;
          timer_d = TIMER_ONE;
        end else begin
          timer_d = TIMER_ZERO;
        end
      end

      DEB_PRESS: begin
        if (!sync_q) begin
          state_d = IDLE;
          timer_d = TIMER_ZERO;
        end else if (timer_q == STABLE_LAST) begin
          state_d = HELD;
          timer_d = TIMER_ZERO;
          ena_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      HELD: begin
        if (!sync_q) begin
          state_d = DEB_RELEASE;
          timer_d = TIMER_ONE;
        end else if (bus.rpt_en && (timer_q == DELAY_LAST)) begin
          state_d = REPEAT;
          timer_d = TIMER_ZERO;
          ena_d   = 1'b1;
        end else if (timer_q != DELAY_LAST) begin
          // Saturate at the delay terminal so a late rpt_en fires at once.
          timer_d = timer_q + TIMER_ONE;
        end
      end

      REPEAT: begin
        if (!sync_q) begin
          state_d = DEB_RELEASE;
          timer_d = TIMER_ONE;
        end else if (!bus.rpt_en) begin
          // Dropping rpt_en restarts the full repeat delay, with no pulse.
          state_d = HELD;
          timer_d = TIMER_ZERO;
        end else if (timer_q == PERIOD_LAST) begin
          timer_d = TIMER_ZERO;
          ena_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      DEB_RELEASE: begin
        if (sync_q) begin
          // Release glitch: back to held, level never dropped, no pulse.
          state_d = HELD;
          timer_d = TIMER_ZERO;
        end else if (timer_q == STABLE_LAST) begin
          state_d = IDLE;
          timer_d = TIMER_ZERO;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = TIMER_ZERO;
      end
    endcase

    // Outputs are registered versions of what the next state implies.
    level_d   = (state_d == HELD) || (state_d == REPEAT) ||
                (state_d == DEB_RELEASE);
    rpt_act_d = (state_d == REPEAT);
  end

  // State, timer and registered outputs; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= TIMER_ZERO;
      ena_q     <= 1'b0;
      level_q   <= 1'b0;
      rpt_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ena_q     <= ena_d;
      level_q   <= level_d;
      rpt_act_q <= rpt_act_d;
    end
  end

  assign bus.ena_pulse     = ena_q;
  assign bus.btn_level     = level_q;
  assign bus.repeat_active = rpt_act_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with STABLE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=5. Each step drives inputs, waits one
// rising edge, samples #1 later and compares against hand-derived values.
module tb_btn_debounce_pulse;

  localparam int STABLE = 4;
  localparam int RDELAY = 20;
  localparam int RPER   = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic prev_ena;

  btn_debounce_pulse_if bus ();

  btn_debounce_pulse #(
    .STABLE_CYCLES (STABLE),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPER),
    .TIMER_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic  btn;
    logic  rpt;
    logic  rs;
    logic  ena;
    logic  lvl;
    logic  rpa;
    string tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic btn, rpt, rs, ena, lvl, rpa,
                              input string tag);
    vec_t v;
    v.btn = btn; v.rpt = rpt; v.rs = rs;
    v.ena = ena; v.lvl = lvl; v.rpa = rpa;
    v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step one edge, compare all outputs.
  task automatic step(input logic btn, rpt, rs, e_ena, e_lvl, e_rpa,
                      input string tag, input int idx);
    bus.btn_in = btn;
    bus.rpt_en = rpt;
    rst        = rs;
    @(posedge clk);
    #1;
    chk({tag, ".ena"}, idx, bus.ena_pulse, e_ena);
    chk({tag, ".lvl"}, idx, bus.btn_level, e_lvl);
    chk({tag, ".rpa"}, idx, bus.repeat_active, e_rpa);
    total++;
    if (prev_ena && bus.ena_pulse) begin
      bad++;
      $display("FAIL %s[%0d].double_pulse got=11 want=not_11", tag, idx);
    end
    prev_ena = bus.ena_pulse;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    prev_ena   = 1'b0;
    rst        = 1'b1;
    bus.btn_in = 1'b0;
    bus.rpt_en = 1'b0;

    // ---- table: reset, clean press, glitch, release, bounce ----
    add(0, 0, 1, 0, 0, 0, "reset");
    add(1, 0, 1, 0, 0, 0, "reset");
    // Clean press: pulse only after edge 6, level from the same cycle.
    for (int k = 1; k <= 40; k++)
      add(1, 0, 0, (k == STABLE + 2), (k >= STABLE + 2), 0, "press");
    // 2-cycle low glitch while held: level stays, no pulse.
    for (int k = 1; k <= 12; k++)
      add((k > 2), 0, 0, 0, 1, 0, "glitch");
    // Release: level falls after edge 6 of low sampling, never a pulse.
    for (int k = 1; k <= 10; k++)
      add(0, 0, 0, 0, (k < STABLE + 2), 0, "release");
    // Bounce 3 high / 1 low / 3 high / low: nothing happens.
    for (int k = 1; k <= 15; k++)
      add((k <= 3) || (k >= 5 && k <= 7), 0, 0, 0, 0, 0, "bounce");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].btn, vecs[i].rpt, vecs[i].rs,
           vecs[i].ena, vecs[i].lvl, vecs[i].rpa, vecs[i].tag, i);

    // ---- auto-repeat: press pulse at 6, repeats at 26, 31, 36 ... ----
    for (int k = 1; k <= 60; k++)
      step(1, 1, 0,
           (k == 6) || (k >= 26 && ((k - 26) % RPER) == 0),
           (k >= 6), (k >= 26), "repeat", k);

    // ---- rpt_en dropped for one cycle in REPEAT, then re-raised ----
    // Edge 61 returns to HELD (timer 0); the delay restarts, so the next
    // pulse lands 20 edges later at 81.
    for (int k = 61; k <= 85; k++)
      step(1, (k != 61), 0, (k == 81), 1, (k >= 81), "rpt_drop", k);

    // ---- reset mid-repeat with button held ----
    step(1, 1, 1, 0, 0, 0, "rst_mid", 0);
    for (int j = 1; j <= 30; j++)
      step(1, 1, 0, (j == 6) || (j == 26), (j >= 6), (j >= 26),
           "rst_after", j);

    // ---- release from REPEAT with rpt_en low: no pulse, level falls ----
    for (int k = 1; k <= 10; k++)
      step(0, 0, 0, 0, (k < 6), 0, "rel_rpt", k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
